gbe_rx_frame_buf: RTL and testbench

- Single-frame receive buffer controller between the GbE RX MAC byte stream and the 2048x8 single-port on-chip RAM.
- Writes one frame into the RAM and checks its length and error status.
- Holds a good frame so the LCD-side consumer can read it at random addresses, then frees the buffer when the consumer releases it.
- Owns the RAM's only port, so writes and reads are mutually exclusive by state.

---
 rtl/gbe_rx_frame_buf.sv | 172 +++++++++++++++++
 tb/tb_gbe_rx_frame_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_rx_frame_buf.sv
// GbE RX single-frame buffer controller: MAC byte stream -> 2048x8 SP RAM.
// Optional statistics counters are built when RXBUF_STATS_EN is defined.
module gbe_rx_frame_buf #(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sof,
    input  logic              rx_eof,
    input  logic              rx_err,
    output logic              frm_ready,
    output logic [ADDR_W:0]   frm_len,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              frm_release,
    output logic              drop_pulse,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic [15:0]       stat_ok_cnt,
    output logic [15:0]       stat_drop_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_L = (ADDR_W+1)'(MIN_LEN);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t            state, state_n;
    logic [ADDR_W:0]   wr_ptr, wr_ptr_n;
    logic [ADDR_W:0]   len_n, eof_len;
    logic              ready_n, drop_n;
    logic              skip, skip_n;
    logic              we, rd_en, eof_chk;
    logic [ADDR_W-1:0] wad;

    assign rd_en = rd_req && (state == HOLD);

    // Next-state, write control and end-of-frame acceptance
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        len_n    = frm_len;
        ready_n  = frm_ready;
        drop_n   = 1'b0;
        skip_n   = skip;
        we       = 1'b0;
        wad      = '0;
        eof_chk  = 1'b0;
        eof_len  = wr_ptr + ONE;
        unique case (state)
            IDLE, DISCARD: begin
                if (rx_valid && rx_sof) begin
                    we       = 1'b1;
                    wr_ptr_n = ONE;
                    state_n  = RECV;
                    eof_chk  = rx_eof;
                    eof_len  = ONE;
                end else if (state == DISCARD && rx_valid && rx_eof) begin
                    state_n = IDLE;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        // restart: the partial frame is abandoned
                        drop_n   = 1'b1;
                        we       = 1'b1;
                        wr_ptr_n = ONE;
                        eof_chk  = rx_eof;
                        eof_len  = ONE;
                    end else if (wr_ptr == DEPTH) begin
                        drop_n  = 1'b1;
                        state_n = rx_eof ? IDLE : DISCARD;
                    end else begin
                        we       = 1'b1;
                        wad      = wr_ptr[ADDR_W-1:0];
                        wr_ptr_n = wr_ptr + ONE;
                        eof_chk  = rx_eof;
                    end
                end
            end
            HOLD: begin
                // frames arriving while held are skipped, RAM is untouched
                if (rx_valid && rx_sof) begin
                    drop_n = 1'b1;
                    skip_n = !rx_eof;
                end else if (rx_valid && rx_eof) begin
                    skip_n = 1'b0;
                end
                if (frm_release) begin
                    ready_n = 1'b0;
                    state_n = skip_n ? DISCARD : IDLE;
                    skip_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (eof_chk) begin
            if (rx_err || eof_len < MIN_L) begin
                drop_n  = 1'b1;
                state_n = IDLE;
            end else begin
                ready_n = 1'b1;
                len_n   = eof_len;
                state_n = HOLD;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            frm_len    <= '0;
            frm_ready  <= 1'b0;
            drop_pulse <= 1'b0;
            skip       <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            frm_len    <= len_n;
            frm_ready  <= ready_n;
            drop_pulse <= drop_n;
            skip       <= skip_n;
            rd_valid   <= rd_en;
        end
    end

    // RAM port: writes only while receiving, reads only while holding
    assign ram_ce  = ~reset & (we | rd_en);
    assign ram_wre = ~reset & we;
    assign ram_oce = 1'b1;
    assign ram_ad  = we ? wad : rd_addr;
    assign ram_din = rx_data;
    assign rd_data = ram_dout;

`ifdef RXBUF_STATS_EN
    logic [15:0] ok_cnt, drop_cnt;

    // Saturating good-frame and drop counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (ready_n && !frm_ready && ok_cnt != 16'hFFFF)
                ok_cnt <= ok_cnt + 16'd1;
            if (drop_n && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign stat_ok_cnt   = ok_cnt;
    assign stat_drop_cnt = drop_cnt;
`else
    assign stat_ok_cnt   = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gbe_rx_frame_buf.sv
// Directed bench for gbe_rx_frame_buf with a behavioural 2048x8 RAM.
// Stats expectations follow RXBUF_STATS_EN.
module tb_gbe_rx_frame_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic        rx_err = 1'b0;
    logic        frm_ready;
    logic [11:0] frm_len;
    logic        rd_req = 1'b0;
    logic [10:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frm_release = 1'b0;
    logic        drop_pulse;
    logic        ram_ce, ram_oce, ram_wre;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [15:0] stat_ok_cnt, stat_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_drop = 0;
    int n_wr = 0;

    logic [7:0] mem [0:2047];

    gbe_rx_frame_buf dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_err(rx_err),
        .frm_ready(frm_ready), .frm_len(frm_len),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .frm_release(frm_release),
        .drop_pulse(drop_pulse),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout),
        .stat_ok_cnt(stat_ok_cnt), .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else if (ram_oce) ram_dout <= mem[ram_ad];
        end
    end

    // Count drop-pulse cycles and RAM writes away from the clock edge
    always @(negedge clk) begin
        if (drop_pulse) n_drop++;
        if (ram_ce && ram_wre) n_wr++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte i of a frame is (i + seed) & 0xFF
    task automatic send_frame(int len, bit err, int seed, bit no_eof);
        for (int i = 0; i < len; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'((i + seed) & 255);
            rx_sof   = (i == 0);
            rx_eof   = (i == len - 1) && !no_eof;
            rx_err   = err && (i == len - 1);
            tick();
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic rd(string tag, int addr, logic [7:0] exp);
        rd_req  = 1'b1;
        rd_addr = 11'(addr);
        tick();
        rd_req  = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk({tag, "_dat"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic release_buf(string tag);
        frm_release = 1'b1;
        tick();
        frm_release = 1'b0;
        chk(tag, 32'(frm_ready), 32'd0);
    endtask

    int d0, w0;
    int exp_ok, exp_drop;

    initial begin
        exp_ok   = 0;
        exp_drop = 0;
        tick();
        tick();
        chk("rst_ready", 32'(frm_ready), 32'd0);
        chk("rst_len", 32'(frm_len), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_drop", 32'(drop_pulse), 32'd0);
        chk("rst_ce", 32'(ram_ce), 32'd0);
        chk("rst_wre", 32'(ram_wre), 32'd0);
        chk("rst_oce", 32'(ram_oce), 32'd1);
        reset = 1'b0;
        tick();

        // 60-byte good frame, then two back-to-back reads
        d0 = n_drop;
        send_frame(60, 1'b0, 0, 1'b0);
        chk("f60_ready", 32'(frm_ready), 32'd1);
        chk("f60_len", 32'(frm_len), 32'd60);
        rd("f60_rd5", 5, 8'h05);
        rd("f60_rd59", 59, 8'h3B);
        chk("f60_nodrop", 32'(n_drop - d0), 32'd0);
        exp_ok++;
        release_buf("f60_rel");

        // read request outside HOLD: no RAM access, no rd_valid
        rd_req  = 1'b1;
        rd_addr = 11'd3;
        #1;
        chk("idle_rd_ce", 32'(ram_ce), 32'd0);
        tick();
        rd_req = 1'b0;
        chk("idle_rd_vld", 32'(rd_valid), 32'd0);

        // 64-byte frame with error
        d0 = n_drop;
        send_frame(64, 1'b1, 0, 1'b0);
        tick();
        chk("err_drop", 32'(n_drop - d0), 32'd1);
        chk("err_ready", 32'(frm_ready), 32'd0);
        exp_drop++;

        // 2100-byte frame overflows the buffer
        d0 = n_drop;
        w0 = n_wr;
        send_frame(2100, 1'b0, 7, 1'b0);
        tick();
        chk("ovf_drop", 32'(n_drop - d0), 32'd1);
        chk("ovf_writes", 32'(n_wr - w0), 32'd2048);
        chk("ovf_last", 32'(mem[2047]), 32'((2047 + 7) & 255));
        chk("ovf_ready", 32'(frm_ready), 32'd0);
        exp_drop++;
        send_frame(64, 1'b0, 3, 1'b0);
        chk("f64_ready", 32'(frm_ready), 32'd1);
        chk("f64_len", 32'(frm_len), 32'd64);
        rd("f64_rd63", 63, 8'h42);
        exp_ok++;
        release_buf("f64_rel");

        // runt and minimum-length frames
        d0 = n_drop;
        send_frame(10, 1'b0, 0, 1'b0);
        tick();
        chk("runt_drop", 32'(n_drop - d0), 32'd1);
        chk("runt_ready", 32'(frm_ready), 32'd0);
        exp_drop++;
        send_frame(14, 1'b0, 8'h20, 1'b0);
        chk("f14_ready", 32'(frm_ready), 32'd1);
        chk("f14_len", 32'(frm_len), 32'd14);
        rd("f14_rd13", 13, 8'h2D);
        exp_ok++;
        release_buf("f14_rel");

        // frame arriving while a frame is held is skipped
        send_frame(100, 1'b0, 8'h40, 1'b0);
        chk("f100_ready", 32'(frm_ready), 32'd1);
        exp_ok++;
        d0 = n_drop;
        w0 = n_wr;
        send_frame(50, 1'b0, 8'h90, 1'b0);
        tick();
        chk("skip_drop", 32'(n_drop - d0), 32'd1);
        chk("skip_wr", 32'(n_wr - w0), 32'd0);
        chk("skip_ready", 32'(frm_ready), 32'd1);
        chk("skip_len", 32'(frm_len), 32'd100);
        chk("skip_mem49", 32'(mem[49]), 32'h71);
        exp_drop++;
        rd("hold_rd0", 0, 8'h40);
        rd("hold_rd99", 99, 8'hA3);
        release_buf("f100_rel");
        send_frame(80, 1'b0, 8'h11, 1'b0);
        chk("f80_ready", 32'(frm_ready), 32'd1);
        chk("f80_len", 32'(frm_len), 32'd80);
        exp_ok++;

        // read and release in the same cycle
        rd_req      = 1'b1;
        rd_addr     = 11'd79;
        frm_release = 1'b1;
        tick();
        rd_req      = 1'b0;
        frm_release = 1'b0;
        chk("rdrel_vld", 32'(rd_valid), 32'd1);
        chk("rdrel_dat", 32'(rd_data), 32'h60);
        chk("rdrel_ready", 32'(frm_ready), 32'd0);

        `ifdef RXBUF_STATS_EN
        chk("stat_ok", 32'(stat_ok_cnt), 32'(exp_ok));
        chk("stat_drop", 32'(stat_drop_cnt), 32'(exp_drop));
        `else
        chk("stat_ok", 32'(stat_ok_cnt), 32'd0);
        chk("stat_drop", 32'(stat_drop_cnt), 32'd0);
        `endif

        // reset in the middle of a frame
        d0 = n_drop;
        send_frame(30, 1'b0, 0, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h1E;
        reset    = 1'b1;
        #1;
        chk("mrst_ce", 32'(ram_ce), 32'd0);
        chk("mrst_wre", 32'(ram_wre), 32'd0);
        chk("mrst_ready", 32'(frm_ready), 32'd0);
        chk("mrst_rdv", 32'(rd_valid), 32'd0);
        tick();
        tick();
        rx_valid = 1'b0;
        reset    = 1'b0;
        tick();
        chk("mrst_nodrop", 32'(n_drop - d0), 32'd0);
        chk("mrst_stat", 32'(stat_drop_cnt), 32'd0);
        send_frame(60, 1'b0, 0, 1'b0);
        chk("post_ready", 32'(frm_ready), 32'd1);
        chk("post_len", 32'(frm_len), 32'd60);
        rd("post_rd30", 30, 8'h1E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
